facto_ctrl: RTL and testbench
=============================

Name: facto_ctrl

Overview:
- Sequencing controller for the FactoCore factorial engine.
- Computes operand! by driving an external 64x64->128 multiplier through a start/done handshake.
- Owns the status and result registers (opdone, result_h, result_l) and the interrupt line.
- These registers feed the core's register read path alongside opstart, opclear, intrEn and operand.

Parameters:
- MUL_W, 64, operand and multiplier input width; result width is 2*MUL_W.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- opstart  input  1  one-cycle start pulse from a register write
- opclear  input  1  one-cycle clear pulse from a register write
- intrEn  input  1  interrupt enable
- operand  input  MUL_W  factorial argument; sampled on the accepted opstart
- mul_done  input  1  one-cycle pulse; mul_result valid this cycle
- mul_result  input  2*MUL_W  product from the multiplier
- mul_start  output  1  one-cycle request pulse to the multiplier
- mul_a  output  MUL_W  multiplicand (running result, low half)
- mul_b  output  MUL_W  multiplier (step counter)
- result_h  output  MUL_W  result bits [127:64]
- result_l  output  MUL_W  result bits [63:0]
- opdone  output  2  [0] done, [1] overflow error
- busy  output  1  high in every state except IDLE and DONE
- interrupt  output  1  intrEn & opdone[0], combinational

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; result_h=0; result_l=1; opdone=0.
  - mul_start=0; mul_a=0; mul_b=0; internal counter i=0; latched N=0.
- States: IDLE, LOAD, MUL_REQ, MUL_WAIT, DONE.
- IDLE: on opstart go to LOAD; latch N=operand; result={0,1}; i=2.
- LOAD:
  - If N<=1: go to DONE with opdone=2'b01 and result=1.
  - Else go to MUL_REQ.
- MUL_REQ:
  - If result_h!=0: go to DONE with opdone=2'b11; result is held as-is and no multiply is issued.
  - Else assert mul_start for exactly one cycle with mul_a=result_l, mul_b=i, then go to MUL_WAIT.
- MUL_WAIT:
  - mul_a and mul_b are held stable.
  - On mul_done: {result_h,result_l}=mul_result.
  - If i==N: go to DONE with opdone=2'b01.
  - Else i=i+1 and go to MUL_REQ.
- DONE: outputs are held. opstart is ignored; a new run requires opclear first.
- Multiply order is ascending (2,3,...,N). 21! is exact. For any N>=22 the overflow check trips before the x22 step.
- opclear:
  - Taken from any state and has priority over opstart in the same cycle.
  - Next state is IDLE; result_h=0; result_l=1; opdone=0; i=0.
  - No mul_start is issued. A mul_done arriving later in IDLE is ignored.
- opstart received in LOAD, MUL_REQ, MUL_WAIT or DONE is ignored.
- mul_start is never asserted while a previous request is outstanding.
- Latency:
  - N<=1: opstart at cycle t gives opdone[0]=1 at t+2.
  - N>=2: each step costs 1 cycle plus the multiplier latency.
- Async reset mid-run returns all state to reset values immediately. Any in-flight mul_done is ignored.

Test Plan:
- Reset, then operand=5, opstart: mul_b sequence 2,3,4,5 is observed, one mul_start per step. Final result_l=120, result_h=0, opdone=2'b01, interrupt=1 with intrEn=1.
- operand=0, and separately operand=1: opdone=2'b01 exactly 2 cycles after opstart, result_l=1, and mul_start is never asserted.
- operand=21: result_h=2, result_l=14197454024290336768 (21!=51090942171709440000), opdone=2'b01.
- operand=22: after the x21 step, the controller goes to DONE with opdone=2'b11 and no x22 request is issued. Result is still 21!.
- opclear pulsed while in MUL_WAIT at the same cycle as opstart, followed by a late mul_done: state is IDLE, result_h=0, result_l=1, opdone=0, busy=0, and the late mul_done is ignored.
- With intrEn=0, run operand=3: opdone=2'b01, result_l=6, interrupt stays 0. Then set intrEn=1: interrupt=1 in the same cycle.

Source files
------------

// File: rtl/facto_ctrl_if.sv
// ---------------------------------------------------------------------------
// facto_ctrl_if
//   Start/done handshake between the factorial sequencer and the external
//   MUL_W x MUL_W -> 2*MUL_W multiplier.
//
//   mul_start  : one-cycle request pulse (controller -> multiplier)
//   mul_a      : multiplicand, held stable while a request is outstanding
//   mul_b      : multiplier operand, held stable while a request is outstanding
//   mul_done   : one-cycle completion pulse (multiplier -> controller)
//   mul_result : product, valid in the cycle mul_done is high
//
//   master modport: the sequencer side; slave modport: the multiplier side.
// ---------------------------------------------------------------------------
interface facto_ctrl_if #(
  parameter int MUL_W = 64
);
  logic               mul_start;
  logic [MUL_W-1:0]   mul_a;
  logic [MUL_W-1:0]   mul_b;
  logic               mul_done;
  logic [2*MUL_W-1:0] mul_result;

  modport master (
    output mul_start, mul_a, mul_b,
    input  mul_done, mul_result
  );

  modport slave (
    input  mul_start, mul_a, mul_b,
    output mul_done, mul_result
  );
endinterface

// File: rtl/facto_ctrl.sv
// ---------------------------------------------------------------------------
// facto_ctrl
//   Sequencing controller of the FactoCore factorial engine. Computes
//   operand! as the ascending product 2*3*...*N using an external multiplier,
//   and owns the result/status registers plus the interrupt line.
//
//   clk, reset_n      : clock (rising edge), async active-low reset
//   opstart, opclear  : one-cycle register-write pulses (clear wins)
//   intrEn            : interrupt enable
//   operand           : factorial argument, sampled on the accepted opstart
//   mul               : multiplier handshake (master side)
//   result_h/result_l : upper / lower halves of the 2*MUL_W result
//   opdone            : [0] done, [1] overflow error
//   busy              : high in every state except IDLE and DONE
//   interrupt         : intrEn & opdone[0]
// ---------------------------------------------------------------------------
module facto_ctrl #(
  parameter int MUL_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             opstart,
  input  logic             opclear,
  input  logic             intrEn,
  input  logic [MUL_W-1:0] operand,
  facto_ctrl_if.master     mul,
  output logic [MUL_W-1:0] result_h,
  output logic [MUL_W-1:0] result_l,
  output logic [1:0]       opdone,
  output logic             busy,
  output logic             interrupt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_DONE
  } state_t;

  localparam logic [2*MUL_W-1:0] RESULT_ONE = (2*MUL_W)'(1);
  localparam logic [MUL_W-1:0]   ONE        = MUL_W'(1);
  localparam logic [MUL_W-1:0]   TWO        = MUL_W'(2);

  state_t             r_state,     w_state_nxt;
  logic [MUL_W-1:0]   r_n,         w_n_nxt;
  logic [MUL_W-1:0]   r_i,         w_i_nxt;
  logic [2*MUL_W-1:0] r_result,    w_result_nxt;
  logic [1:0]         r_opdone,    w_opdone_nxt;
  logic               r_mul_start, w_mul_start_nxt;
  logic [MUL_W-1:0]   r_mul_a,     w_mul_a_nxt;
  logic [MUL_W-1:0]   r_mul_b,     w_mul_b_nxt;
  // A request is outstanding from mul_start until its mul_done. It survives
  // opclear so that a new run cannot launch on top of an abandoned request
  // and then mistake the stale mul_done for its own product.
  logic               r_mul_pend,  w_mul_pend_nxt;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_i         <= '0;
      r_result    <= RESULT_ONE;
      r_opdone    <= '0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_n         <= w_n_nxt;
      r_i         <= w_i_nxt;
      r_result    <= w_result_nxt;
      r_opdone    <= w_opdone_nxt;
      r_mul_start <= w_mul_start_nxt;
      r_mul_a     <= w_mul_a_nxt;
      r_mul_b     <= w_mul_b_nxt;
      r_mul_pend  <= w_mul_pend_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_n_nxt         = r_n;
    w_i_nxt         = r_i;
    w_result_nxt    = r_result;
    w_opdone_nxt    = r_opdone;
    w_mul_start_nxt = 1'b0;
    w_mul_a_nxt     = r_mul_a;
    w_mul_b_nxt     = r_mul_b;
    w_mul_pend_nxt  = r_mul_pend;

    if (mul.mul_done) begin
      w_mul_pend_nxt = 1'b0;
    end

    if (opclear) begin
      w_state_nxt  = S_IDLE;
      w_result_nxt = RESULT_ONE;
      w_opdone_nxt = 2'b00;
      w_i_nxt      = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (opstart) begin
            w_state_nxt  = S_LOAD;
            w_n_nxt      = operand;
            w_result_nxt = RESULT_ONE;
            w_i_nxt      = TWO;
          end
        end

        S_LOAD: begin
          if (r_n <= ONE) begin
            w_state_nxt  = S_DONE;
            w_opdone_nxt = 2'b01;
            w_result_nxt = RESULT_ONE;
          end else begin
            w_state_nxt = S_MUL_REQ;
          end
        end

        S_MUL_REQ: begin
          // A non-zero upper half means the next step could exceed the
          // result width, so stop before issuing it.
          if (r_result[2*MUL_W-1:MUL_W] != '0) begin
            w_state_nxt  = S_DONE;
            w_opdone_nxt = 2'b11;
          end else if (!r_mul_pend) begin
            w_mul_start_nxt = 1'b1;
            w_mul_pend_nxt  = 1'b1;
            w_mul_a_nxt     = r_result[MUL_W-1:0];
            w_mul_b_nxt     = r_i;
            w_state_nxt     = S_MUL_WAIT;
          end
        end

        S_MUL_WAIT: begin
          if (mul.mul_done) begin
            w_result_nxt = mul.mul_result;
            if (r_i == r_n) begin
              w_state_nxt  = S_DONE;
              w_opdone_nxt = 2'b01;
            end else begin
              w_i_nxt     = r_i + ONE;
              w_state_nxt = S_MUL_REQ;
            end
          end
        end

        S_DONE: begin
          // Results held; only opclear leaves this state.
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign mul.mul_start = r_mul_start;
  assign mul.mul_a     = r_mul_a;
  assign mul.mul_b     = r_mul_b;

  assign result_h  = r_result[2*MUL_W-1:MUL_W];
  assign result_l  = r_result[MUL_W-1:0];
  assign opdone    = r_opdone;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign interrupt = intrEn & r_opdone[0];

endmodule

// File: tb/tb_facto_ctrl.sv
// ---------------------------------------------------------------------------
// tb_facto_ctrl
//   Self-checking bench for facto_ctrl. A behavioural multiplier answers each
//   request after a random latency; a reference model computes the expected
//   product sequence, final result and status directly from the factorial
//   definition and the overflow rule.
// ---------------------------------------------------------------------------
module tb_facto_ctrl;
  localparam int MUL_W = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             opstart;
  logic             opclear;
  logic             intrEn;
  logic [MUL_W-1:0] operand;
  logic [MUL_W-1:0] result_h;
  logic [MUL_W-1:0] result_l;
  logic [1:0]       opdone;
  logic             busy;
  logic             interrupt;

  facto_ctrl_if #(.MUL_W(MUL_W)) mul ();

  facto_ctrl #(.MUL_W(MUL_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opstart   (opstart),
    .opclear   (opclear),
    .intrEn    (intrEn),
    .operand   (operand),
    .mul       (mul),
    .result_h  (result_h),
    .result_l  (result_l),
    .opdone    (opdone),
    .busy      (busy),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Multiplier model: samples requests at the falling edge, answers with
  // a one-cycle mul_done after 1..4 cycles (or a forced latency).
  // ------------------------------------------------------------------
  int           force_lat   = -1;
  bit           m_pending   = 1'b0;
  int           m_cnt       = 0;
  logic [127:0] m_prod;
  int           done_cnt    = 0;
  int           overlap_cnt = 0;
  logic [63:0]  seen_a[$];
  logic [63:0]  seen_b[$];

  always @(negedge clk) begin
    mul.mul_done = 1'b0;
    if (m_pending) begin
      if (m_cnt == 0) begin
        mul.mul_done   = 1'b1;
        mul.mul_result = m_prod;
        m_pending      = 1'b0;
        done_cnt++;
      end else begin
        m_cnt--;
      end
    end
    if (mul.mul_start === 1'b1) begin
      if (m_pending) overlap_cnt++;
      seen_a.push_back(mul.mul_a);
      seen_b.push_back(mul.mul_b);
      m_prod    = {64'd0, mul.mul_a} * {64'd0, mul.mul_b};
      m_pending = 1'b1;
      m_cnt     = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
    end
  end

  // Clears the core, launches operand n and checks the whole run.
  task automatic run_fact(input logic [63:0] n, input string tag);
    logic [127:0] m_res;
    logic [1:0]   m_od;
    logic [63:0]  q_a[$];
    logic [63:0]  q_b[$];
    int           base;
    int           cyc;
    bit           seen;

    m_res = 128'd1;
    m_od  = 2'b01;
    for (longint unsigned k = 2; k <= n; k++) begin
      if (m_res[127:64] != 64'd0) begin
        m_od = 2'b11;
        break;
      end
      q_a.push_back(m_res[63:0]);
      q_b.push_back(k);
      m_res = m_res * {64'd0, k};
    end

    opclear = 1'b1;
    @(negedge clk);
    opclear = 1'b0;
    operand = n;
    opstart = 1'b1;
    base    = seen_b.size();
    @(negedge clk);
    opstart = 1'b0;
    cyc     = 1;
    seen    = 1'b0;
    if (n <= 64'd1) check({tag, "_opdone_t1"}, opdone, 2'b00);
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (opdone != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_finished"}, seen, 1'b1);
    if (n <= 64'd1) check({tag, "_latency"}, cyc, 2);
    check({tag, "_result"}, {result_h, result_l}, m_res);
    check({tag, "_opdone"}, opdone, m_od);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_interrupt"}, interrupt, intrEn);
    check({tag, "_nsteps"}, seen_b.size() - base, q_b.size());
    for (int j = 0; j < q_b.size() && base + j < seen_b.size(); j++) begin
      check($sformatf("%s_mul_b%0d", tag, j), seen_b[base+j], q_b[j]);
      check($sformatf("%s_mul_a%0d", tag, j), seen_a[base+j], q_a[j]);
    end
    check({tag, "_overlap"}, overlap_cnt, 0);
  endtask

  initial begin
    int base;
    int dsnap;
    bit seen;
    logic [63:0] rn;

    reset_n = 1'b0;
    opstart = 1'b0;
    opclear = 1'b0;
    intrEn  = 1'b0;
    operand = '0;
    repeat (3) @(negedge clk);
    check("rst_result_h", result_h, 64'd0);
    check("rst_result_l", result_l, 64'd1);
    check("rst_opdone", opdone, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_mul_start", mul.mul_start, 1'b0);
    check("rst_mul_a", mul.mul_a, 64'd0);
    check("rst_mul_b", mul.mul_b, 64'd0);
    check("rst_interrupt", interrupt, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    // 5! with interrupt enabled.
    intrEn = 1'b1;
    run_fact(64'd5, "f5");
    check("f5_result_l_const", result_l, 64'd120);
    check("f5_interrupt_const", interrupt, 1'b1);

    // opstart in DONE is ignored.
    base    = seen_b.size();
    operand = 64'd3;
    opstart = 1'b1;
    @(negedge clk);
    opstart = 1'b0;
    repeat (3) @(negedge clk);
    check("done_ign_result_l", result_l, 64'd120);
    check("done_ign_opdone", opdone, 2'b01);
    check("done_ign_busy", busy, 1'b0);
    check("done_ign_starts", seen_b.size() - base, 0);

    // Trivial arguments.
    run_fact(64'd0, "f0");
    run_fact(64'd1, "f1");

    // Largest exact argument and first overflowing one.
    run_fact(64'd21, "f21");
    check("f21_h_const", result_h, 64'd2);
    check("f21_l_const", result_l, 64'd14197454024290336768);
    run_fact(64'd22, "f22");
    check("f22_h_const", result_h, 64'd2);
    check("f22_l_const", result_l, 64'd14197454024290336768);

    // opclear together with opstart during MUL_WAIT, then a late mul_done.
    force_lat = 5;
    opclear   = 1'b1;
    @(negedge clk);
    opclear = 1'b0;
    operand = 64'd5;
    opstart = 1'b1;
    base    = seen_b.size();
    @(negedge clk);
    opstart = 1'b0;
    seen    = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (seen_b.size() > base) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("clr_req_seen", seen, 1'b1);
    dsnap   = done_cnt;
    opclear = 1'b1;
    opstart = 1'b1;
    @(negedge clk);
    opclear = 1'b0;
    opstart = 1'b0;
    check("clr_busy", busy, 1'b0);
    check("clr_result_l", result_l, 64'd1);
    check("clr_opdone", opdone, 2'b00);
    repeat (8) @(negedge clk);
    check("clr_late_done_arrived", done_cnt - dsnap, 1);
    check("clr_late_result_h", result_h, 64'd0);
    check("clr_late_result_l", result_l, 64'd1);
    check("clr_late_opdone", opdone, 2'b00);
    check("clr_late_busy", busy, 1'b0);
    check("clr_late_starts", seen_b.size() - base, 1);
    force_lat = -1;

    // Async reset in the middle of a run.
    force_lat = 3;
    opclear   = 1'b1;
    @(negedge clk);
    opclear = 1'b0;
    operand = 64'd10;
    opstart = 1'b1;
    base    = seen_b.size();
    @(negedge clk);
    opstart = 1'b0;
    seen    = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (seen_b.size() >= base + 3) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("arst_progress", seen, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_result_h", result_h, 64'd0);
    check("arst_result_l", result_l, 64'd1);
    check("arst_opdone", opdone, 2'b00);
    check("arst_mul_start", mul.mul_start, 1'b0);
    check("arst_mul_b", mul.mul_b, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_late_result_l", result_l, 64'd1);
    check("arst_late_busy", busy, 1'b0);
    check("arst_late_opdone", opdone, 2'b00);
    force_lat = -1;

    // Interrupt gating.
    intrEn = 1'b0;
    run_fact(64'd3, "intr");
    check("intr_result_l_const", result_l, 64'd6);
    check("intr_off", interrupt, 1'b0);
    intrEn = 1'b1;
    #1;
    check("intr_on_same_cycle", interrupt, 1'b1);
    @(negedge clk);

    // Randomized arguments, including very large ones.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 5) == 0) rn = {$urandom, $urandom} | 64'h100;
      else rn = 64'($urandom_range(0, 24));
      intrEn = 1'($urandom_range(0, 1));
      run_fact(rn, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
